// File: rtl/shot_responder.sv
// shot_responder: defender-side end of the shot exchange.
//
// Holds the local GRID x GRID ship map (4-bit ship id plus a "shot" bit per
// cell). The ship-placement logic writes it, and incoming shots are looked
// up in it. For each shot the block returns a 2-bit result code. It also
// tracks the remaining cells of each ship and flags defeat.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   place_we        placement write strobe (honoured in IDLE only)
//   place_addr      placement cell, row [7:4], col [3:0]
//   place_id        ship id to store (1..N_SHIPS)
//   place_clear     start-new-game request, wipes the map (IDLE only)
//   shot_valid      incoming shot address valid
//   shot_addr       incoming shot, row [7:4], col [3:0]
//   shot_ready      a shot can be accepted this cycle
//   result_valid    result code valid, held until result_ready
//   result          00 none, 01 miss, 10 hit, 11 sunk
//   result_ready    consumer takes the result
//   cells_left      unhit ship cells remaining
//   all_sunk        every placed ship cell has been hit (sticky)
//   busy            clear sequence in progress
module shot_responder #(
  parameter int unsigned GRID    = 10,
  parameter int unsigned N_SHIPS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       place_we,
  input  logic [7:0] place_addr,
  input  logic [3:0] place_id,
  input  logic       place_clear,
  input  logic       shot_valid,
  input  logic [7:0] shot_addr,
  output logic       shot_ready,
  output logic       result_valid,
  output logic [1:0] result,
  input  logic       result_ready,
  output logic [6:0] cells_left,
  output logic       all_sunk,
  output logic       busy
);

  localparam int unsigned CELLS = GRID * GRID;
  localparam int unsigned IDXW  = $clog2(CELLS);

  localparam logic [3:0]      GRID_L    = 4'(GRID);
  localparam logic [3:0]      MAX_ID    = 4'(N_SHIPS);
  localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(CELLS - 1);
  localparam logic [6:0]      CELLS_MAX = 7'(CELLS);

  localparam logic [1:0] RES_MISS = 2'b01;
  localparam logic [1:0] RES_HIT  = 2'b10;
  localparam logic [1:0] RES_SUNK = 2'b11;

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    LOOKUP,
    EVAL,
    REPLY
  } state_t;

  function automatic logic addr_ok(input logic [7:0] a);
    return (a[7:4] < GRID_L) && (a[3:0] < GRID_L);
  endfunction

  // Only meaningful when addr_ok() holds; wraps silently otherwise.
  function automatic logic [IDXW-1:0] cell_idx(input logic [7:0] a);
    return IDXW'(a[7:4]) * IDXW'(GRID) + IDXW'(a[3:0]);
  endfunction

  state_t          state;
  logic [IDXW-1:0] clr_idx;
  logic [3:0]      map_id   [CELLS];
  logic            map_shot [CELLS];
  logic [6:0]      ship_len [16];
  logic            armed;

  logic [IDXW-1:0] shot_idx;
  logic [3:0]      rd_id;
  logic            rd_shot;

  logic [IDXW-1:0] place_idx;
  logic            place_ok;

  assign busy       = (state == CLEAR);
  assign shot_ready = (state == IDLE) && !place_we && !place_clear;

  // The occupancy check reads the map directly, so a placement completes
  // in one cycle without a read-modify-write pass.
  assign place_idx = cell_idx(place_addr);
  assign place_ok  = addr_ok(place_addr) &&
                     (map_id[place_idx] == 4'd0) &&
                     (place_id != 4'd0) && (place_id <= MAX_ID);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= CLEAR;
      clr_idx      <= '0;
      result_valid <= 1'b0;
      result       <= '0;
      cells_left   <= '0;
      all_sunk     <= 1'b0;
      armed        <= 1'b0;
      ship_len     <= '{default: '0};
    end else begin
      case (state)
        CLEAR: begin
          map_id[clr_idx]   <= '0;
          map_shot[clr_idx] <= 1'b0;
          if (clr_idx == LAST_IDX) begin
            clr_idx <= '0;
            state   <= IDLE;
          end else begin
            clr_idx <= clr_idx + 1'b1;
          end
        end

        IDLE: begin
          if (place_clear) begin
            state      <= CLEAR;
            clr_idx    <= '0;
            cells_left <= '0;
            all_sunk   <= 1'b0;
            armed      <= 1'b0;
            ship_len   <= '{default: '0};
          end else if (place_we) begin
            if (place_ok) begin
              map_id[place_idx] <= place_id;
              ship_len[place_id] <= ship_len[place_id] + 1'b1;
              if (cells_left < CELLS_MAX)
                cells_left <= cells_left + 1'b1;
              armed <= 1'b1;
            end
          end else if (shot_valid) begin
            shot_idx <= cell_idx(shot_addr);
            state    <= LOOKUP;
            // Invalid addresses are folded into "already shot" here so that
            // EVAL treats them as a plain miss with no state change.
            if (addr_ok(shot_addr)) begin
              rd_shot <= 1'b0;
            end else begin
              rd_shot <= 1'b1;
            end
          end
        end

        LOOKUP: begin
          if (!rd_shot) begin
            rd_id   <= map_id[shot_idx];
            rd_shot <= map_shot[shot_idx];
          end else begin
            rd_id <= '0;
          end
          state <= EVAL;
        end

        EVAL: begin
          result_valid <= 1'b1;
          state        <= REPLY;
          if (rd_shot) begin
            result <= RES_MISS;
          end else begin
            map_shot[shot_idx] <= 1'b1;
            if (rd_id == 4'd0) begin
              result <= RES_MISS;
            end else begin
              if (ship_len[rd_id] != 7'd0)
                ship_len[rd_id] <= ship_len[rd_id] - 1'b1;
              result <= (ship_len[rd_id] <= 7'd1) ? RES_SUNK : RES_HIT;
              if (cells_left != 7'd0) begin
                cells_left <= cells_left - 1'b1;
                if ((cells_left == 7'd1) && armed)
                  all_sunk <= 1'b1;
              end
            end
          end
        end

        REPLY: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            result       <= '0;
            state        <= IDLE;
          end
        end

        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_shot_responder.sv
// Directed bench for shot_responder. Expected reply codes and counter values
// are pushed to a scoreboard queue when a shot is driven and compared when
// result_valid appears.
module tb_shot_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       place_we;
  logic [7:0] place_addr;
  logic [3:0] place_id;
  logic       place_clear;
  logic       shot_valid;
  logic [7:0] shot_addr;
  logic       shot_ready;
  logic       result_valid;
  logic [1:0] result;
  logic       result_ready;
  logic [6:0] cells_left;
  logic       all_sunk;
  logic       busy;

  always #5 clk = ~clk;

  shot_responder #(.GRID(10), .N_SHIPS(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .place_we     (place_we),
    .place_addr   (place_addr),
    .place_id     (place_id),
    .place_clear  (place_clear),
    .shot_valid   (shot_valid),
    .shot_addr    (shot_addr),
    .shot_ready   (shot_ready),
    .result_valid (result_valid),
    .result       (result),
    .result_ready (result_ready),
    .cells_left   (cells_left),
    .all_sunk     (all_sunk),
    .busy         (busy)
  );

  typedef struct {
    logic [1:0] res;
    logic [6:0] cells;
    logic       sunk;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic count_busy(input string tag);
    int cnt = 0;
    while (busy && cnt < 200) begin
      tick();
      cnt++;
    end
    chk(tag, cnt, 100);
  endtask

  task automatic place(input logic [7:0] a, input logic [3:0] id);
    place_we   = 1'b1;
    place_addr = a;
    place_id   = id;
    #1;
    chk($sformatf("shot_ready_low_during_place_%h", a), shot_ready, 0);
    tick();
    place_we = 1'b0;
  endtask

  task automatic wait_result(input string tag);
    int   lat = 0;
    exp_t e;
    while (!result_valid && lat < 10) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, 2);
    chk({tag, "_sb_nonempty"}, (sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_result"}, result, e.res);
      chk({tag, "_cells_left"}, cells_left, e.cells);
      chk({tag, "_all_sunk"}, all_sunk, e.sunk);
    end
  endtask

  task automatic push_exp(input logic [1:0] r, input logic [6:0] c, input logic s);
    exp_t e;
    e.res   = r;
    e.cells = c;
    e.sunk  = s;
    sb.push_back(e);
  endtask

  task automatic shoot(input logic [7:0] a, input logic [1:0] r, input logic [6:0] c,
                       input logic s, input int hold);
    string tag;
    tag = $sformatf("shot_%h", a);
    push_exp(r, c, s);
    result_ready = (hold == 0);
    shot_valid   = 1'b1;
    shot_addr    = a;
    #1;
    chk({tag, "_ready"}, shot_ready, 1);
    tick();
    shot_valid = 1'b0;
    wait_result(tag);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, "_hold_result"}, result, r);
      chk({tag, "_hold_valid"}, result_valid, 1);
      chk({tag, "_hold_shot_ready"}, shot_ready, 0);
    end
    result_ready = 1'b1;
    tick();
    chk({tag, "_done_valid"}, result_valid, 0);
    chk({tag, "_done_result"}, result, 0);
    chk({tag, "_done_idle"}, shot_ready, 1);
  endtask

  initial begin
    rst          = 1'b1;
    place_we     = 1'b0;
    place_addr   = '0;
    place_id     = '0;
    place_clear  = 1'b0;
    shot_valid   = 1'b0;
    shot_addr    = '0;
    result_ready = 1'b1;

    tick();
    tick();
    chk("rst_busy", busy, 1);
    chk("rst_shot_ready", shot_ready, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_cells_left", cells_left, 0);
    chk("rst_all_sunk", all_sunk, 0);
    rst = 1'b0;
    count_busy("reset_clear_cycles");
    chk("idle_shot_ready", shot_ready, 1);
    chk("idle_cells_left", cells_left, 0);
    chk("idle_all_sunk", all_sunk, 0);

    place(8'h33, 4'd2);
    place(8'h34, 4'd2);
    place(8'h35, 4'd2);
    place(8'h90, 4'd1);
    chk("placed_cells_left", cells_left, 4);
    place(8'h33, 4'd1);
    chk("occupied_write_ignored", cells_left, 4);
    place(8'hA0, 4'd1);
    chk("bad_row_write_ignored", cells_left, 4);
    place(8'h01, 4'd6);
    chk("bad_id_write_ignored", cells_left, 4);
    place(8'h02, 4'd0);
    chk("zero_id_write_ignored", cells_left, 4);

    shoot(8'h34, 2'b10, 7'd3, 1'b0, 0);
    shoot(8'h34, 2'b01, 7'd3, 1'b0, 0);
    shoot(8'h00, 2'b01, 7'd3, 1'b0, 0);
    shoot(8'h01, 2'b01, 7'd3, 1'b0, 0);
    shoot(8'hA0, 2'b01, 7'd3, 1'b0, 0);
    shoot(8'h3A, 2'b01, 7'd3, 1'b0, 0);
    shoot(8'h33, 2'b10, 7'd2, 1'b0, 0);
    shoot(8'h35, 2'b11, 7'd1, 1'b0, 0);
    shoot(8'h90, 2'b11, 7'd0, 1'b1, 5);
    shoot(8'h90, 2'b01, 7'd0, 1'b1, 0);

    // Clear wins over a simultaneous shot.
    place_clear = 1'b1;
    shot_valid  = 1'b1;
    shot_addr   = 8'h34;
    #1;
    chk("clear_blocks_shot_ready", shot_ready, 0);
    tick();
    place_clear = 1'b0;
    shot_valid  = 1'b0;
    chk("clear_busy", busy, 1);
    chk("clear_all_sunk_zeroed", all_sunk, 0);
    count_busy("clear_cycles");
    chk("after_clear_all_sunk", all_sunk, 0);
    chk("after_clear_cells_left", cells_left, 0);
    chk("after_clear_no_reply", result_valid, 0);
    place(8'h33, 4'd4);
    chk("map_wiped_place_ok", cells_left, 1);

    // Reset during REPLY.
    push_exp(2'b11, 7'd0, 1'b1);
    result_ready = 1'b0;
    shot_valid   = 1'b1;
    shot_addr    = 8'h33;
    tick();
    shot_valid = 1'b0;
    wait_result("rst_in_reply");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    result_ready = 1'b1;
    chk("rst_in_reply_valid", result_valid, 0);
    chk("rst_in_reply_busy", busy, 1);
    count_busy("rst_in_reply_clear_cycles");
    chk("rst_in_reply_cells_left", cells_left, 0);
    chk("rst_in_reply_all_sunk", all_sunk, 0);
    chk("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shot_responder.md
Name: shot_responder

Overview:
- Defender-side end of the shot exchange between the two boards.
- The attacking side issues an 8-bit shot address (row [7:4], col [3:0], same encoding as mouse_position). This block looks the address up in the local ship map and returns a 2-bit result code (miss/hit/sunk) on the msg lines.
- Holds the local 10x10 ship map, which the ship-placement logic writes. Tracks per-ship remaining cells and flags defeat.

Parameters:
- GRID, 10, board side length; valid row/col values are 0..GRID-1.
- N_SHIPS, 5, highest valid ship id; ids are 1..N_SHIPS, and id 0 means an empty cell.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- place_we  in  1  placement write strobe.
- place_addr  in  8  placement cell, row [7:4], col [3:0].
- place_id  in  4  ship id to store in the cell.
- place_clear  in  1  start-new-game request; wipes the map.
- shot_valid  in  1  incoming shot address valid.
- shot_addr  in  8  incoming shot, row [7:4], col [3:0].
- shot_ready  out  1  block can accept a shot this cycle.
- result_valid  out  1  result code valid.
- result  out  2  00 none, 01 miss, 10 hit, 11 sunk.
- result_ready  in  1  consumer takes the result.
- cells_left  out  7  unhit ship cells remaining.
- all_sunk  out  1  every placed ship cell has been hit (sticky).
- busy  out  1  clear sequence in progress.

Behaviour:
- Single clock clk. Reset rst is synchronous, active-high.
- Reset values:
  - state = CLEAR, clear index = 0, busy = 1.
  - shot_ready = 0, result_valid = 0, result = 00.
  - cells_left = 0, all_sunk = 0, armed = 0.
  - All per-ship length counters = 0.
- Reset asserted mid-operation aborts any pending reply and restarts CLEAR.
- Map storage: 100 entries, each holding a 4-bit id and a shot bit. Linear index = row*GRID + col. Read is synchronous, 1-cycle latency.
- An address is valid only if row < GRID and col < GRID.

States:
- CLEAR:
  - Writes id = 0 and shot = 0 at index 0..99, one entry per cycle.
  - busy = 1 throughout.
  - Exits to IDLE after index 99, so CLEAR lasts exactly 100 cycles.
  - Counters, armed and all_sunk are zeroed on entry.
- IDLE:
  - shot_ready = !place_we && !place_clear.
  - Priority: place_clear > place_we > shot.
  - place_clear goes to CLEAR.
  - place_we stores place_id into the cell only if all of these hold:
    - address is valid;
    - cell id is currently 0;
    - place_id is in 1..N_SHIPS.
  - An accepted write increments ship_len[place_id] and cells_left, and sets armed. Any other write is ignored silently.
  - shot_valid && shot_ready captures shot_addr and goes to LOOKUP.
- LOOKUP: one cycle for the map read, then EVAL.
- EVAL: one cycle to classify the shot and update state, then REPLY.
  - Invalid address: result 01; no state change.
  - Cell already shot: result 01; no state change.
  - Empty cell: set shot bit; result 01.
  - Ship cell, not yet shot:
    - set shot bit;
    - decrement ship_len[id] and cells_left;
    - result is 11 if ship_len[id] reaches 0, otherwise 10.
  - all_sunk is set on the same edge that cells_left reaches 0 with armed = 1.
- REPLY:
  - result_valid = 1; result holds stable until result_valid && result_ready.
  - On that handshake: result_valid goes to 0, result to 00, state to IDLE.
- Latency: a shot accepted at edge T gives result_valid = 1 from edge T+2. Counters update on that same edge.
- Counter bounds:
  - cells_left saturates at 100 and never underflows.
  - ship_len never underflows, because a cell is decremented at most once (guarded by the shot bit).
- place_we and place_clear outside IDLE are ignored; they are not queued.
- all_sunk is cleared only by CLEAR or reset.
- A shot arriving after all_sunk is still answered normally (01 for repeat cells).

Test Plan:
- Reset, then idle: busy = 1 for exactly 100 cycles, then shot_ready = 1; cells_left = 0; all_sunk = 0.
- Place ship 2 at 0x33, 0x34, 0x35 and ship 1 at 0x90: cells_left = 4. Re-write 0x33 with id 1: ignored, cells_left stays 4. Write at 0xA0: ignored.
- Shot 0x34 -> result 10 at T+2, cells_left = 3. Repeat shot 0x34 -> 01, no change. Shot 0x00 -> 01.
- Shots 0x33 then 0x35 -> 10 then 11. Shot 0x90 -> 11, cells_left = 0, all_sunk = 1 on the same edge as result_valid.
- Hold result_ready = 0 for 5 cycles: result stays 11 with result_valid = 1 and shot_ready = 0. Release: returns to IDLE the next cycle.
- place_clear and shot_valid in the same IDLE cycle: shot is not accepted, busy for 100 cycles, then all_sunk = 0. Separately, assert rst during REPLY: result_valid = 0 on the next cycle and CLEAR restarts.
